gf180mcu_fd_sc_mcu9t5v0_subh_serial: RTL and testbench
======================================================

Name: gf180mcu_fd_sc_mcu9t5v0_subh_serial

Overview:
- Bit-serial unsigned subtractor (A − B). It is the inverse-direction counterpart of the half-adder cell.
- Consumes operand bits LSB-first on A/B, one bit per clock. Produces a running difference bit, a final borrow, and the parallel WIDTH-bit result.
- Built from two half-subtractor stages plus a borrow flop, a bit counter and a result shift register.
- Used in standard-cell-based datapath characterisation blocks and in small serial ALUs.

Parameters:
- WIDTH, 8: operand and result width in bits. Legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock
- RN  input  1  asynchronous active-low reset
- START  input  1  begins a new subtraction when sampled high in IDLE
- A  input  1  minuend bit, LSB first
- B  input  1  subtrahend bit, LSB first
- D  output  1  registered difference bit of the most recent RUN cycle
- BO  output  1  registered final borrow; valid while DONE=1 and held until next START
- BUSY  output  1  high in RUN
- DONE  output  1  single-cycle completion pulse
- Q  output  WIDTH  parallel result; held until next accepted START

Interface (already decided): one clock, CLK; reset RN is asynchronous and active-low.

Behaviour:
- Reset (RN low, asynchronous): state=IDLE; borrow, count, D, BO, BUSY, DONE = 0; Q = 0. Outputs stay cleared until the first CLK edge after RN rises.
- States: IDLE, RUN, DONE.
- IDLE:
  - START=1 at an edge → RUN. At the same edge: count=0, internal borrow=0, BO=0.
  - A/B are not sampled on the START edge.
- RUN, at each edge with count=i:
  - Sample A_i and B_i.
  - Stage 1: d1 = A^B; b1 = ~A&B.
  - Stage 2: diff = d1^borrow; b2 = ~d1&borrow.
  - borrow_next = b1|b2.
  - D ← diff.
  - Q ← {diff, Q[WIDTH-1:1]}, i.e. shift right with diff entering at the MSB.
  - count ← i+1.
- RUN exit: at the edge with count=WIDTH-1 → DONE. BO ← borrow_next.
- DONE: DONE=1 and BUSY=0 for exactly one cycle, then → IDLE unconditionally.
- Latency: the START edge is edge 0. Bits are sampled on edges 1..WIDTH. DONE is high in the cycle after edge WIDTH.
- START while in RUN or DONE is ignored; no queuing.
- A/B values in IDLE/DONE are don't-care and have no effect.
- Arithmetic: result = (A − B) mod 2^WIDTH. BO=1 iff A < B (unsigned).
- The counter uses clog2(WIDTH) bits. It never wraps, because the exit compare happens at WIDTH-1.
- Reset mid-RUN: immediate return to the reset values. The partial Q is discarded.

Optional Feature:
- Macro: GF180MCU_SUBH_SERIAL_SAT_EN.
- Defined: unsigned saturation. On the transition to DONE, if the final borrow is 1, Q is forced to 0. BO still reports 1. D is unaffected; it still shows the raw serial bits.
- Undefined: Q holds the wrapped modulo-2^WIDTH result.

Decomposition:
- Shared package holds:
  - state enum typedef {IDLE, RUN, DONE} (2 bits)
  - CNT_W = clog2(WIDTH) localparam function
  - half-subtractor truth constants used by the checkers
- Sub-module: gf180mcu_fd_sc_mcu9t5v0_subh_func, a combinational half subtractor with D = A^B and BO = ~A&B.
  - Instantiated twice to form the full-subtract stage.
  - Also reused stand-alone by the verification checker.

Test Plan:
- Reset, then WIDTH=8, A=0x35, B=0x12 → DONE on cycle 9 after START; Q=0x23; BO=0; serial D stream LSB-first 1,1,0,0,0,1,0,0.
- A=0x12, B=0x35 → Q=0xDD, BO=1. With GF180MCU_SUBH_SERIAL_SAT_EN defined → Q=0x00, BO=1.
- A=0xFF, B=0xFF, then back-to-back A=0x00, B=0x01 with START asserted in the DONE cycle (ignored, so re-asserted in IDLE) → first Q=0x00, BO=0; second Q=0xFF, BO=1.
- START held high throughout RUN → exactly one DONE pulse per accepted START; BUSY high for exactly 8 cycles.
- RN pulsed low at count=4 during A=0x80, B=0x01 → Q, D, BO, BUSY, DONE all 0 immediately. A following clean run gives Q=0x7F, BO=0.
- WIDTH=2 build, A=0b01, B=0b10 → Q=0b11, BO=1; DONE 3 cycles after START.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_subh_serial_pkg.sv
// gf180mcu_fd_sc_mcu9t5v0_subh_serial_pkg: shared FSM states, counter width and half-subtractor truth tables
package gf180mcu_fd_sc_mcu9t5v0_subh_serial_pkg;
  // Prefixed so the literals do not collide with the DONE port of the top
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
  // Indexed by {a, b}
  localparam logic [3:0] HS_D_TT  = 4'b0110;
  localparam logic [3:0] HS_BO_TT = 4'b0010;
endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_subh_func.sv
// gf180mcu_fd_sc_mcu9t5v0_subh_func: combinational half subtractor (D = A^B, BO = ~A&B)
module gf180mcu_fd_sc_mcu9t5v0_subh_func (
  input  logic A,
  input  logic B,
  output logic D,
  output logic BO
);
  assign D  = A ^ B;
  assign BO = ~A & B;
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_subh_serial.sv
// gf180mcu_fd_sc_mcu9t5v0_subh_serial: LSB-first bit-serial A-B; GF180MCU_SUBH_SERIAL_SAT_EN clamps Q to 0 on final borrow
module gf180mcu_fd_sc_mcu9t5v0_subh_serial
  import gf180mcu_fd_sc_mcu9t5v0_subh_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             A,
  input  logic             B,
  output logic             D,
  output logic             BO,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef GF180MCU_SUBH_SERIAL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic borrow, d1, b1, diff, b2, borrow_nxt, last;
  gf180mcu_fd_sc_mcu9t5v0_subh_func u_s1 (.A(A),  .B(B),      .D(d1),   .BO(b1));
  gf180mcu_fd_sc_mcu9t5v0_subh_func u_s2 (.A(d1), .B(borrow), .D(diff), .BO(b2));
  assign borrow_nxt = b1 | b2;
  assign last = cnt == LAST;
  // State register
  always_ff @(posedge CLK or negedge RN)
    if (!RN) state <= S_IDLE;
    else state <= state_nxt;
  // Next state and status outputs; the unused encoding falls back to idle
  always_comb begin
    state_nxt = state == S_IDLE ? (START ? S_RUN : S_IDLE) :
                state == S_RUN  ? (last ? S_DONE : S_RUN) : S_IDLE;
    BUSY = state == S_RUN;
    DONE = state == S_DONE;
  end
  // Serial datapath: borrow chain, difference bit, result shift register and final borrow
  always_ff @(posedge CLK or negedge RN)
    if (!RN) begin
      cnt    <= '0;
      borrow <= 1'b0;
      D      <= 1'b0;
      BO     <= 1'b0;
      Q      <= '0;
    end else if (state == S_IDLE && START) begin
      cnt    <= '0;
      borrow <= 1'b0;
      BO     <= 1'b0;
    end else if (state == S_RUN) begin
      cnt    <= last ? cnt : cnt + CW'(1);
      borrow <= borrow_nxt;
      D      <= diff;
      Q      <= (last && SAT && borrow_nxt) ? '0 : {diff, Q[WIDTH-1:1]};
      if (last) BO <= borrow_nxt;
    end
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_subh_serial.sv
// tb_gf180mcu_fd_sc_mcu9t5v0_subh_serial: directed bench with arithmetic reference model for the serial subtractor
module tb_gf180mcu_fd_sc_mcu9t5v0_subh_serial;
  import gf180mcu_fd_sc_mcu9t5v0_subh_serial_pkg::*;
  localparam int W = 8;
`ifdef GF180MCU_SUBH_SERIAL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rn = 1'b0, start = 1'b0, a = 1'b0, b = 1'b0;
  logic d, bo, busy, done;
  logic [W-1:0] q;
  logic st2 = 1'b0, a2 = 1'b0, b2 = 1'b0;
  logic d2, bo2, busy2, done2;
  logic [1:0] q2;
  logic ha = 1'b0, hb = 1'b0, hd, hbo;
  int checks = 0, failures = 0;
  bit m_busy = 0, m_done = 0, m_d = 0, m_bo = 0, m_qv = 1;
  logic [W-1:0] m_q = '0, ma = '0, mb = '0, diffv = '0, dstream = '0;
  int k = 0, busy_cnt = 0, done_cnt = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0_subh_serial #(.WIDTH(W)) dut (
    .CLK(clk), .RN(rn), .START(start), .A(a), .B(b),
    .D(d), .BO(bo), .BUSY(busy), .DONE(done), .Q(q)
  );
  gf180mcu_fd_sc_mcu9t5v0_subh_serial #(.WIDTH(2)) dut2 (
    .CLK(clk), .RN(rn), .START(st2), .A(a2), .B(b2),
    .D(d2), .BO(bo2), .BUSY(busy2), .DONE(done2), .Q(q2)
  );
  gf180mcu_fd_sc_mcu9t5v0_subh_func hs (.A(ha), .B(hb), .D(hd), .BO(hbo));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collects operand bits and derives every output arithmetically
  always @(posedge clk or negedge rn) begin
    if (!rn) begin
      m_busy = 0; m_done = 0; m_d = 0; m_bo = 0; m_q = '0; m_qv = 1; k = 0;
    end else if (m_done) m_done = 0;
    else if (m_busy) begin
      ma[k] = a;
      mb[k] = b;
      k++;
      diffv = ma - mb;
      m_d = diffv[k-1];
      if (k == W) begin
        m_busy = 0;
        m_done = 1;
        m_bo = ma < mb;
        m_q = (SAT && ma < mb) ? '0 : diffv;
        m_qv = 1;
      end
    end else if (start) begin
      m_busy = 1; k = 0; ma = '0; mb = '0; m_bo = 0; m_qv = 0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("d", d, m_d);
    chk("bo", bo, m_bo);
    if (m_qv) chk("q", q, m_q);
    if ((m_busy && k > 0) || m_done) dstream[k-1] = d;
    busy_cnt += busy;
    done_cnt += done;
  end

  task automatic sub(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold, input int abort);
    int n = 0;
    start = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!busy && n < 4);
    chk("accept", busy, 1'b1);
    for (int i = 0; i < W; i++) begin
      if (i == abort) begin
        rn = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_q", q, 0);
        chk("rst_d", d, 0);
        chk("rst_bo", bo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        return;
      end
      a = av[i];
      b = bv[i];
      start = hold;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_pulse", done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", q, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bo", bo, 0);
    rn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {ha, hb} = 2'(i);
      #1;
      chk("hs_d", hd, HS_D_TT[i]);
      chk("hs_bo", hbo, HS_BO_TT[i]);
    end
    sub(8'h35, 8'h12, 0, -1);
    @(negedge clk); #1;
    chk("q_35_12", q, 8'h23);
    chk("bo_35_12", bo, 0);
    chk("dstream_35_12", dstream, 8'h23);
    sub(8'h12, 8'h35, 0, -1);
    @(negedge clk); #1;
    chk("q_12_35", q, SAT ? 8'h00 : 8'hDD);
    chk("bo_12_35", bo, 1);
    chk("dstream_12_35", dstream, 8'hDD);
    sub(8'hFF, 8'hFF, 0, -1);
    @(negedge clk); #1;
    chk("q_ff_ff", q, 8'h00);
    chk("bo_ff_ff", bo, 0);
    sub(8'h00, 8'h01, 0, -1);
    @(negedge clk); #1;
    chk("q_00_01", q, SAT ? 8'h00 : 8'hFF);
    chk("bo_00_01", bo, 1);
    @(posedge clk); #1;
    busy_cnt = 0;
    done_cnt = 0;
    sub(8'h5A, 8'h3C, 1, -1);
    repeat (3) @(negedge clk);
    #1;
    chk("busy_cycles", busy_cnt, 8);
    chk("done_pulses", done_cnt, 1);
    chk("q_5a_3c", q, 8'h1E);
    sub(8'h80, 8'h01, 0, 4);
    @(posedge clk); #1;
    rn = 1'b1;
    sub(8'h80, 8'h01, 0, -1);
    @(negedge clk); #1;
    chk("q_80_01", q, 8'h7F);
    chk("bo_80_01", bo, 0);
    @(posedge clk); #1;
    st2 = 1'b1;
    @(posedge clk); #1;
    st2 = 1'b0;
    chk("w2_busy", busy2, 1);
    a2 = 1'b1; b2 = 1'b0;
    @(posedge clk); #1;
    a2 = 1'b0; b2 = 1'b1;
    @(posedge clk); #1;
    chk("w2_done", done2, 1);
    chk("w2_q", q2, SAT ? 2'b00 : 2'b11);
    chk("w2_bo", bo2, 1);
    @(posedge clk); #1;
    chk("w2_done_clear", done2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
